bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial sequence detectors (Moore/Mealy 010101).

---
 rtl/serial_pkg.sv | 18 +
 rtl/bit_serializer.sv | 124 ++++++++++++
 tb/tb_bit_serializer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serializer front end and the serial sequence detector benches.
package serial_pkg;

   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_SHIFT = 2'd1,
      SER_GAP   = 2'd2
   } ser_state_t;

   // Pattern recognised by the downstream Moore/Mealy detectors.
   localparam logic [5:0] SEQ_PATTERN = 6'b010101;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready handshake and
// shifts them out one bit per clock, with an optional idle gap between words.
module bit_serializer
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_bit,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output ser_state_t       dbg_state
);

   // Handshake: a word transfers on a posedge where in_valid && in_ready; in_ready is
   // low in reset, high in IDLE, and in SHIFT only on the last bit when GAP==0 and a
   // follow-on word is offered, so back-to-back words leave no bubble.

   localparam int unsigned    CW       = cnt_w(WIDTH);
   localparam int unsigned    GW       = cnt_w(GAP + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

   ser_state_t       state_q,  state_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [GW-1:0]    gapcnt_q, gapcnt_d;

   logic             head_bit;
   logic [WIDTH-1:0] shreg_shifted;
   logic             on_last;
   logic             xfer;

   assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};
   assign on_last       = (state_q == SER_SHIFT) && (bitcnt_q == '0);

   always_comb begin
      in_ready = 1'b0;
      if (reset) begin
         case (state_q)
            SER_IDLE:  in_ready = 1'b1;
            SER_SHIFT: in_ready = on_last && (GAP == 0) && in_valid;
            default:   in_ready = 1'b0;
         endcase
      end
   end

   assign xfer = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      case (state_q)
         SER_IDLE: begin
            if (xfer) begin
               state_d  = SER_SHIFT;
               shreg_d  = in_data;
               bitcnt_d = CNT_LOAD;
            end
         end
         SER_SHIFT: begin
            if (bitcnt_q != '0) begin
               shreg_d  = shreg_shifted;
               bitcnt_d = bitcnt_q - CW'(1);
            end else if (xfer) begin
               shreg_d  = in_data;
               bitcnt_d = CNT_LOAD;
            end else if (GAP == 0) begin
               state_d = SER_IDLE;
               shreg_d = '0;
            end else begin
               state_d  = SER_GAP;
               shreg_d  = '0;
               gapcnt_d = GAP_LOAD;
            end
         end
         SER_GAP: begin
            if (gapcnt_q == '0) begin
               state_d = SER_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - GW'(1);
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= SER_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
      end
   end

   // Serial outputs come from registered state only.
   assign ser_valid = (state_q == SER_SHIFT);
   assign ser_bit   = ser_valid ? head_bit : IDLE_BIT;
   assign ser_last  = on_last;
   assign busy      = (state_q != SER_IDLE);
   assign dbg_state = state_q;

   a_last_in_word : assert property (@(posedge clk) ser_last |-> ser_valid);
   a_idle_level   : assert property (@(posedge clk) !ser_valid |-> (ser_bit == IDLE_BIT));

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two configurations checked every cycle against a
// queue-of-expected-line-cycles model, plus hand-computed bit patterns.
module tb_bit_serializer;
   import serial_pkg::*;

   localparam int NI = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] din [NI];
   logic       vin [NI];
   logic       rdy [NI];
   logic       sb  [NI];
   logic       sv  [NI];
   logic       sl  [NI];
   logic       bz  [NI];
   ser_state_t st  [NI];

   // inst 0: MSB first, back-to-back; inst 1: LSB first, 2-cycle gap
   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .GAP(0)) u_a (
      .clk(clk), .reset(rst_n), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
      .ser_bit(sb[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0]), .dbg_state(st[0]));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(2)) u_b (
      .clk(clk), .reset(rst_n), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
      .ser_bit(sb[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1]), .dbg_state(st[1]));

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic bit msb_of(input int i);
      return (i == 0);
   endfunction

   // ---------------- scoreboard / model ----------------
   // Each queue entry is one future line cycle: {valid, last, bit}. Empty queue = idle.
   logic [2:0] mq [NI][$];
   logic       lg [NI][$];
   int         run_cur [NI];
   int         run_max [NI];
   int         idle_busy [NI];
   int         rdy_busy [NI];
   int         last_cnt [NI];
   int         total = 0;
   int         bad = 0;
   bit         started = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic clr_stats();
      for (int i = 0; i < NI; i++) begin
         lg[i].delete();
         run_cur[i] = 0; run_max[i] = 0; idle_busy[i] = 0; rdy_busy[i] = 0; last_cnt[i] = 0;
      end
   endtask

   function automatic logic [31:0] log_val(input int i);
      logic [31:0] v;
      v = '0;
      foreach (lg[i][k]) v = {v[30:0], lg[i][k]};
      return v;
   endfunction

   // Single compare process: check this cycle, then advance the model to the next one.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < NI; i++) begin
            logic [2:0] f;
            logic       e_rdy;
            logic [4:0] e_o;
            logic [4:0] g_o;
            logic       has;
            has   = (mq[i].size() != 0);
            f     = has ? mq[i][0] : 3'b001;
            e_rdy = rst_n && (!has || (mq[i].size() == 1 && f[2] && f[1] && gap_of(i) == 0 && vin[i]));
            e_o   = {e_rdy, f[2], f[1], f[0], has};
            g_o   = {rdy[i], sv[i], sl[i], sb[i], bz[i]};
            total++;
            if (g_o !== e_o) begin
               bad++;
               $display("FAIL cycle inst=%0d t=%0t {rdy,val,last,bit,busy} got=%b exp=%b",
                        i, $time, g_o, e_o);
            end
            if (sv[i]) lg[i].push_back(sb[i]);
            run_cur[i] = sv[i] ? run_cur[i] + 1 : 0;
            if (run_cur[i] > run_max[i]) run_max[i] = run_cur[i];
            if (bz[i] && !sv[i]) idle_busy[i]++;
            if (rdy[i] && bz[i]) rdy_busy[i]++;
            if (sl[i]) last_cnt[i]++;
            if (!rst_n) begin
               mq[i].delete();
            end else begin
               if (has) begin
                  void'(mq[i].pop_front());
                  if (f[2] && f[1])
                     for (int g = 0; g < gap_of(i); g++) mq[i].push_back(3'b001);
               end
               if (vin[i] && e_rdy)
                  for (int k = 0; k < 8; k++)
                     mq[i].push_back({1'b1, k == 7, din[i][msb_of(i) ? 7 - k : k]});
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int i, input logic [7:0] d, input bit keep);
      int n;
      vin[i] = 1'b1;
      din[i] = d;
      n = 0;
      @(negedge clk);
      while (!rdy[i] && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (n >= 300) check($sformatf("handshake_timeout_%0d", i), 0, 1);
      @(posedge clk); #1;
      if (!keep) vin[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while (mq[i].size() != 0 && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (n >= 400) check($sformatf("idle_timeout_%0d", i), 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rand_driver(input int i, input int words);
      for (int w = 0; w < words; w++) begin
         if (!vin[i]) cycles($urandom_range(0, 3));
         send(i, 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
      end
      vin[i] = 1'b0;
      wait_idle(i);
   endtask

   task automatic rand_reset(input int times);
      for (int r = 0; r < times; r++) begin
         cycles($urandom_range(100, 500));
         rst_n = 1'b0;
         cycles($urandom_range(1, 3));
         rst_n = 1'b1;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < NI; i++) begin
         vin[i] = 1'b0;
         din[i] = 8'h00;
      end
      clr_stats();
      @(posedge clk);
      started = 1'b1;
      #1;
      cycles(2);
      @(negedge clk);
      check("reset_ser_bit", 32'(sb[0]), 1);
      check("reset_ser_valid", 32'(sv[0]), 0);
      check("reset_busy", 32'(bz[0]), 0);
      check("reset_in_ready", 32'(rdy[0]), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(rdy[0]), 1);
      @(posedge clk); #1;

      // single word, MSB first
      clr_stats();
      send(0, 8'h55, 1'b0);
      wait_idle(0);
      check("w55_bits", log_val(0), 32'h55);
      check("w55_count", lg[0].size(), 8);
      check("w55_last_once", last_cnt[0], 1);
      check("w55_detect_tail", log_val(0) & 32'h3f, 32'(SEQ_PATTERN));

      // back-to-back words
      clr_stats();
      send(0, 8'h55, 1'b1);
      send(0, 8'hAA, 1'b0);
      wait_idle(0);
      check("b2b_bits", log_val(0), 32'h55AA);
      check("b2b_run", run_max[0], 16);
      check("b2b_ready_busy", rdy_busy[0], 1);

      // gap of 2 between LSB-first words
      clr_stats();
      send(1, 8'h55, 1'b1);
      send(1, 8'hAA, 1'b0);
      wait_idle(1);
      check("gap_bits", log_val(1), 32'hAA55);
      check("gap_idle_busy", idle_busy[1], 4);
      check("gap_run", run_max[1], 8);

      // LSB first pattern
      clr_stats();
      send(1, 8'hA5, 1'b0);
      wait_idle(1);
      check("lsb_a5_bits", log_val(1), 32'hA5);

      // reset during bit 4
      clr_stats();
      send(0, 8'h55, 1'b0);
      cycles(3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midreset_valid", 32'(sv[0]), 0);
      check("midreset_bit", 32'(sb[0]), 1);
      check("midreset_partial", lg[0].size(), 4);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cycles(2);
      clr_stats();
      send(0, 8'h0F, 1'b0);
      wait_idle(0);
      cycles(3);
      check("after_reset_bits", log_val(0), 32'h0F);
      check("after_reset_count", lg[0].size(), 8);

      // randomized traffic with occasional resets
      fork
         rand_driver(0, 150);
         rand_driver(1, 150);
         rand_reset(2);
      join
      rst_n = 1'b1;
      wait_idle(0);
      wait_idle(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
